// File: rtl/hit_or_ts_pkg.sv
// Shared field widths, limits and word layout for the HIT_OR time-stamper.
package hit_or_ts_pkg;

    localparam int ID_W   = 4;
    localparam int TS_W   = 16;
    localparam int TOT_W  = 12;
    localparam int WORD_W = ID_W + TS_W + TOT_W;

    localparam logic [TOT_W-1:0] TOT_MAX  = 12'hFFF;
    localparam logic [TS_W-1:0]  MARK_TS  = 16'h0000;
    localparam logic [TOT_W-1:0] MARK_TOT = 12'h000;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [TS_W-1:0]  ts;
        logic [TOT_W-1:0] tot;
    } hit_word_t;

    function automatic logic [TOT_W-1:0] tot_inc(input logic [TOT_W-1:0] t);
        return (t == TOT_MAX) ? t : t + 12'd1;
    endfunction

endpackage

// File: rtl/hit_or_ts_fifo.sv
// Synchronous first-word-fall-through FIFO; push accepted when full if a pop
// happens in the same cycle.
module hit_or_ts_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      cnt <= cnt + 1'b1;
            else if (do_pop && !do_push) cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/hit_or_ts.sv
// HIT_OR time-over-threshold word generator with output FIFO.
// Optional wrap marker words: define HIT_OR_TS_WRAP_MARKER_EN.
module hit_or_ts
    import hit_or_ts_pkg::*;
#(
    parameter logic [ID_W-1:0] DATA_IDENTIFIER = 4'b0101,
    parameter int              DEPTH           = 16
) (
    input  logic              BUS_CLK,
    input  logic              BUS_RST,
    input  logic              HIT_IN,
    input  logic              ENABLE,
    input  logic              FIFO_READ,
    output logic              FIFO_EMPTY,
    output logic [WORD_W-1:0] FIFO_DATA,
    output logic [7:0]        LOST_CNT
);

    logic [2:0]       sync;
    logic             hit_s;
    logic             hit_d;
    logic             rise;
    logic             fall;
    logic [TS_W-1:0]  ts;
    logic [TS_W-1:0]  ts_cap;
    logic [TOT_W-1:0] tot;
    logic [7:0]       lost;
    logic             hit_push;
    logic             push;
    logic             full;
    hit_word_t        word;

    assign hit_s    = sync[2];
    assign rise     = hit_s & ~hit_d;
    assign fall     = ~hit_s & hit_d;
    assign hit_push = fall & ENABLE;

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            sync   <= '0;
            hit_d  <= 1'b0;
            ts     <= '0;
            ts_cap <= '0;
            tot    <= '0;
        end else begin
            sync  <= {sync[1:0], HIT_IN};
            hit_d <= hit_s;
            ts    <= ts + 16'd1;
            if (rise) begin
                ts_cap <= ts;
                tot    <= 12'd1;
            end else if (hit_s) begin
                tot <= tot_inc(tot);
            end
        end
    end

`ifdef HIT_OR_TS_WRAP_MARKER_EN
    logic wrap;
    logic pend;
    logic mark_push;

    assign wrap      = (ts == '1);
    // A marker colliding with a hit word is deferred one cycle.
    assign mark_push = (wrap & ~hit_push) | pend;
    assign push      = hit_push | mark_push;

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) pend <= 1'b0;
        else         pend <= wrap & hit_push;
    end

    always_comb begin
        word = '{DATA_IDENTIFIER, MARK_TS, MARK_TOT};
        if (hit_push) word = '{DATA_IDENTIFIER, ts_cap, tot};
    end
`else
    assign push = hit_push;

    always_comb begin
        word = '{DATA_IDENTIFIER, ts_cap, tot};
    end
`endif

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            lost <= '0;
        end else if (push && full && !FIFO_READ && lost != 8'hFF) begin
            lost <= lost + 8'd1;
        end
    end

    assign LOST_CNT = lost;

    hit_or_ts_fifo #(
        .DEPTH (DEPTH),
        .W     (WORD_W)
    ) u_fifo (
        .clk   (BUS_CLK),
        .rst   (BUS_RST),
        .push  (push),
        .pop   (FIFO_READ),
        .wdata (word),
        .rdata (FIFO_DATA),
        .empty (FIFO_EMPTY),
        .full  (full)
    );

endmodule
